// File: rtl/lookup_engine_tcam.sv
// lookup_engine_tcam
//
// Ternary match table with a two-stage lookup pipeline and a control port
// carried over AXI-Stream for table writes.
//
// Lookup path
//   - A key arrives on key_in with its per-lookup mask key_mask_in and the
//     PHV on phv_in. The key is qualified by key_valid_in.
//   - Stage 1 registers the per-entry match vector together with the PHV.
//   - Stage 2 registers the priority-encoded result, so phv_valid_out
//     follows key_valid_in by two cycles.
//   - A new key can be accepted on every cycle.
//   - While phv_valid_out is low, phv_out, match_addr_out and
//     match_hit_out keep their last values.
//
// Control path
//   - Control packets arrive on c_s_axis_*. There is no back-pressure.
//   - A header addressed to LKE_ID writes the next beat into the key or
//     mask slot of one entry.
//   - Every other packet is forwarded on c_m_axis_* one cycle later.
//
// Ports
//   clk, rst                        clock; asynchronous active-high reset
//   phv_in, key_in, key_mask_in,
//   key_valid_in                    lookup request
//   phv_out, phv_valid_out,
//   match_addr_out, match_hit_out   lookup result
//   hit_cnt_out                     saturating hit counter (0 when disabled)
//   c_s_axis_*                      control stream in
//   c_m_axis_*                      control stream out
//   ctrl_state                      control FSM state, for observation
//
// Build option
//   LKE_HIT_CNT_EN enables the 32-bit hit counter. When this macro is
//   undefined, hit_cnt_out is tied to 0.
//
// Handshake
//   Both streams use valid-only semantics. A beat is transferred on every
//   rising edge where tvalid=1, because the sink never stalls. For the
//   same reason, key_valid_in is accepted on every cycle where it is high.
module lookup_engine_tcam #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PHV_LEN              = 1124,
  parameter int KEY_LEN              = 197,
  parameter int DEPTH                = 16,
  parameter int LKE_ID               = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic [KEY_LEN-1:0]                key_in,
  input  logic [KEY_LEN-1:0]                key_mask_in,
  input  logic                              key_valid_in,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_valid_out,
  output logic [$clog2(DEPTH)-1:0]          match_addr_out,
  output logic                              match_hit_out,
  output logic [31:0]                       hit_cnt_out,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [1:0]                        ctrl_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_WRITE   = 2'd1,
    C_BYPASS  = 2'd2,
    C_DISCARD = 2'd3
  } ctrl_state_t;

  // Table storage
  logic [KEY_LEN-1:0] key_tbl  [DEPTH];
  logic [KEY_LEN-1:0] mask_tbl [DEPTH];
  logic [DEPTH-1:0]   entry_valid;

  // Lookup: match against the registered table, so a write in the same
  // cycle is seen only by later lookups.
  logic [DEPTH-1:0] match_vec;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = entry_valid[i] &&
                     ~|((key_in ^ key_tbl[i]) & mask_tbl[i] & key_mask_in);
    end
  end

  logic               s1_valid;
  logic [DEPTH-1:0]   s1_match;
  logic [PHV_LEN-1:0] s1_phv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
      s1_phv   <= '0;
    end else begin
      s1_valid <= key_valid_in;
      if (key_valid_in) begin
        s1_match <= match_vec;
        s1_phv   <= phv_in;
      end
    end
  end

  // Lowest index wins: scan downward so the last assignment is the lowest.
  logic [AW-1:0] enc_addr;
  logic          enc_hit;

  always_comb begin
    enc_addr = '0;
    enc_hit  = |s1_match;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_match[i]) enc_addr = AW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_valid_out  <= 1'b0;
      phv_out        <= '0;
      match_addr_out <= '0;
      match_hit_out  <= 1'b0;
    end else begin
      phv_valid_out <= s1_valid;
      if (s1_valid) begin
        phv_out        <= s1_phv;
        match_addr_out <= enc_addr;
        match_hit_out  <= enc_hit;
      end
    end
  end

`ifdef LKE_HIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_out <= '0;
    end else if (phv_valid_out && match_hit_out && (hit_cnt_out != 32'hFFFF_FFFF)) begin
      hit_cnt_out <= hit_cnt_out + 32'd1;
    end
  end
`else
  assign hit_cnt_out = '0;
`endif

  // Control header decode
  logic [7:0] hdr_id;
  logic [3:0] hdr_type;
  logic [7:0] hdr_idx;
  logic       hdr_id_ok;
  logic       hdr_write;

  always_comb begin
    hdr_id    = c_s_axis_tdata[112 +: 8];
    hdr_type  = c_s_axis_tdata[124 +: 4];
    hdr_idx   = c_s_axis_tdata[128 +: 8];
    hdr_id_ok = (hdr_id == 8'(LKE_ID));
    hdr_write = hdr_id_ok &&
                ((hdr_type == 4'd1) || (hdr_type == 4'd2)) &&
                ({24'd0, hdr_idx} < 32'(DEPTH));
  end

  // Control FSM
  ctrl_state_t state_q, state_d;
  logic        fwd;
  logic        tbl_wr;
  logic        latch_hdr;
  logic        wr_is_key_q;
  logic [AW-1:0] wr_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    tbl_wr    = 1'b0;
    latch_hdr = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (c_s_axis_tvalid) begin
          if (hdr_write) begin
            // A write header that is also the last beat has no payload.
            // It is absorbed, and the FSM stays here.
            if (!c_s_axis_tlast) begin
              latch_hdr = 1'b1;
              state_d   = C_WRITE;
            end
          end else begin
            fwd = 1'b1;
            if (!c_s_axis_tlast) state_d = C_BYPASS;
          end
        end
      end
      C_WRITE: begin
        if (c_s_axis_tvalid) begin
          tbl_wr  = 1'b1;
          state_d = c_s_axis_tlast ? C_IDLE : C_DISCARD;
        end
      end
      C_BYPASS: begin
        if (c_s_axis_tvalid) begin
          fwd = 1'b1;
          if (c_s_axis_tlast) state_d = C_IDLE;
        end
      end
      C_DISCARD: begin
        if (c_s_axis_tvalid && c_s_axis_tlast) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  assign ctrl_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_is_key_q <= 1'b0;
      wr_idx_q    <= '0;
    end else if (latch_hdr) begin
      wr_is_key_q <= (hdr_type == 4'd1);
      wr_idx_q    <= hdr_idx[AW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_tbl[i]  <= '0;
        mask_tbl[i] <= '0;
      end
    end else if (tbl_wr) begin
      if (wr_is_key_q) begin
        key_tbl[wr_idx_q]     <= c_s_axis_tdata[KEY_LEN-1:0];
        entry_valid[wr_idx_q] <= 1'b1;
      end else begin
        mask_tbl[wr_idx_q] <= c_s_axis_tdata[KEY_LEN-1:0];
      end
    end
  end

  // Forwarded beats leave one cycle after they arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd;
      if (fwd) begin
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
        c_m_axis_tlast <= c_s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_lookup_engine_tcam.sv
module tb_lookup_engine_tcam;

  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int PL  = 1124;
  localparam int KL  = 197;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int CW  = 1124;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PL-1:0] phv_in = '0;
  logic [KL-1:0] key_in = '0;
  logic [KL-1:0] key_mask_in = '0;
  logic          key_valid_in = 1'b0;
  logic [PL-1:0] phv_out;
  logic          phv_valid_out;
  logic [AW-1:0] match_addr_out;
  logic          match_hit_out;
  logic [31:0]   hit_cnt_out;
  logic [DW-1:0]   s_tdata = '0;
  logic [UW-1:0]   s_tuser = '0;
  logic [DW/8-1:0] s_tkeep = '1;
  logic            s_tvalid = 1'b0;
  logic            s_tlast = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic [UW-1:0]   m_tuser;
  logic [DW/8-1:0] m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic [1:0]      ctrl_state;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_hits = 0;

  always #5 clk = ~clk;

  lookup_engine_tcam #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .PHV_LEN(PL),
    .KEY_LEN(KL), .DEPTH(DEP), .LKE_ID(2)
  ) dut (
    .clk(clk), .rst(rst),
    .phv_in(phv_in), .key_in(key_in), .key_mask_in(key_mask_in),
    .key_valid_in(key_valid_in),
    .phv_out(phv_out), .phv_valid_out(phv_valid_out),
    .match_addr_out(match_addr_out), .match_hit_out(match_hit_out),
    .hit_cnt_out(hit_cnt_out),
    .c_s_axis_tdata(s_tdata), .c_s_axis_tuser(s_tuser), .c_s_axis_tkeep(s_tkeep),
    .c_s_axis_tvalid(s_tvalid), .c_s_axis_tlast(s_tlast),
    .c_m_axis_tdata(m_tdata), .c_m_axis_tuser(m_tuser), .c_m_axis_tkeep(m_tkeep),
    .c_m_axis_tvalid(m_tvalid), .c_m_axis_tlast(m_tlast),
    .ctrl_state(ctrl_state)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [7:0] id, input logic [3:0] typ,
                                           input logic [7:0] idx);
    logic [DW-1:0] h;
    h = '0;
    h[119:112] = id;
    h[127:124] = typ;
    h[135:128] = idx;
    return h;
  endfunction

  function automatic logic [PL-1:0] mk_phv(input logic [31:0] s);
    logic [PL-1:0] p;
    p = '0;
    p[31:0] = s;
    p[PL-1 -: 32] = ~s;
    return p;
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] typ, input logic [7:0] idx,
                             input logic [DW-1:0] d);
    send_beat(mk_hdr(8'd2, typ, idx), 1'b0);
    send_beat(d, 1'b1);
  endtask

  task automatic lookup(input string tag, input logic [7:0] k, input logic [31:0] ps,
                        input logic exp_hit, input logic [AW-1:0] exp_addr);
    key_in       = '0;
    key_in[7:0]  = k;
    key_mask_in  = '1;
    phv_in       = mk_phv(ps);
    key_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid_in = 1'b0;
    chk({tag, "_s1_not_valid"}, CW'(phv_valid_out), CW'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, CW'(phv_valid_out), CW'(1'b1));
    chk({tag, "_hit"},   CW'(match_hit_out), CW'(exp_hit));
    chk({tag, "_addr"},  CW'(match_addr_out), CW'(exp_addr));
    chk({tag, "_phv"},   phv_out, mk_phv(ps));
    if (exp_hit) exp_hits++;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef LKE_HIT_CNT_EN
    return 32'(exp_hits);
`else
    return 32'd0;
`endif
  endfunction

  logic [DW-1:0] beats [3];
  logic          burst_hit;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_phv_valid", CW'(phv_valid_out), CW'(1'b0));
    chk("rst_hit",       CW'(match_hit_out), CW'(1'b0));
    chk("rst_addr",      CW'(match_addr_out), CW'(4'd0));
    chk("rst_phv",       phv_out, '0);
    chk("rst_hit_cnt",   CW'(hit_cnt_out), CW'(32'd0));
    chk("rst_m_tvalid",  CW'(m_tvalid), CW'(1'b0));
    chk("rst_state",     CW'(ctrl_state), CW'(2'd0));

    // Empty table: miss, address 0
    lookup("empty", 8'hAB, 32'h1111_0001, 1'b0, 4'd0);
    @(negedge clk);
    chk("empty_hit_cnt", CW'(hit_cnt_out), CW'(32'd0));

    // Key 0xAB at index 3, mask all-ones
    send_beat(mk_hdr(8'd2, 4'd1, 8'd3), 1'b0);
    chk("wr_hdr_state", CW'(ctrl_state), CW'(2'd1));
    chk("wr_hdr_not_fwd", CW'(m_tvalid), CW'(1'b0));
    send_beat(DW'(8'hAB), 1'b1);
    chk("wr_data_state", CW'(ctrl_state), CW'(2'd0));
    write_entry(4'd2, 8'd3, '1);
    lookup("idx3", 8'hAB, 32'h2222_0002, 1'b1, 4'd3);

    // Key 0x10 at 5 (with a trailing beat to discard) and at 2
    send_beat(mk_hdr(8'd2, 4'd1, 8'd5), 1'b0);
    send_beat(DW'(8'h10), 1'b0);
    chk("discard_state", CW'(ctrl_state), CW'(2'd3));
    send_beat({DW{1'b1}}, 1'b1);
    chk("discard_not_fwd", CW'(m_tvalid), CW'(1'b0));
    chk("discard_done", CW'(ctrl_state), CW'(2'd0));
    write_entry(4'd2, 8'd5, '1);
    write_entry(4'd1, 8'd2, DW'(8'h10));
    write_entry(4'd2, 8'd2, '1);
    lookup("prio", 8'h10, 32'h3333_0003, 1'b1, 4'd2);

    // 3-beat packet for module id 1 is forwarded one cycle later
    beats[0] = mk_hdr(8'd1, 4'd1, 8'd3) | DW'(64'hDEAD_BEEF_0000_00AB);
    beats[1] = {8{32'hA5A5_0F0F}};
    beats[2] = {4{64'h0123_4567_89AB_CDEF}};
    s_tuser  = {4{32'hC0DE_0001}};
    s_tkeep  = 32'h00FF_FF0F;
    for (int i = 0; i < 3; i++) begin
      send_beat(beats[i], (i == 2));
      chk($sformatf("byp_tvalid_%0d", i), CW'(m_tvalid), CW'(1'b1));
      chk($sformatf("byp_tdata_%0d", i),  CW'(m_tdata), CW'(beats[i]));
      chk($sformatf("byp_tlast_%0d", i),  CW'(m_tlast), CW'(i == 2));
      chk($sformatf("byp_state_%0d", i),  CW'(ctrl_state), CW'((i == 2) ? 2'd0 : 2'd2));
    end
    chk("byp_tuser", CW'(m_tuser), CW'({4{32'hC0DE_0001}}));
    chk("byp_tkeep", CW'(m_tkeep), CW'(32'h00FF_FF0F));
    s_tkeep = '1;
    @(posedge clk);
    @(negedge clk);
    chk("byp_idle_tvalid", CW'(m_tvalid), CW'(1'b0));
    lookup("byp_tbl3", 8'hAB, 32'h4444_0004, 1'b1, 4'd3);
    lookup("byp_tbl2", 8'h10, 32'h4444_0005, 1'b1, 4'd2);

    // Single-beat header for this id: absorbed, nothing written
    send_beat(mk_hdr(8'd2, 4'd1, 8'd0), 1'b1);
    chk("one_beat_not_fwd", CW'(m_tvalid), CW'(1'b0));
    chk("one_beat_state", CW'(ctrl_state), CW'(2'd0));
    lookup("one_beat_nowr", 8'h00, 32'h5555_0006, 1'b0, 4'd0);

    // Out-of-range index and bad type: forwarded
    send_beat(mk_hdr(8'd2, 4'd1, 8'd20), 1'b1);
    chk("oor_idx_fwd", CW'(m_tvalid), CW'(1'b1));
    chk("oor_idx_data", CW'(m_tdata), CW'(mk_hdr(8'd2, 4'd1, 8'd20)));
    send_beat(mk_hdr(8'd2, 4'd3, 8'd1), 1'b1);
    chk("bad_type_fwd", CW'(m_tvalid), CW'(1'b1));
    chk("bad_type_data", CW'(m_tdata), CW'(mk_hdr(8'd2, 4'd3, 8'd1)));
    @(posedge clk);
    @(negedge clk);

    // 8 back-to-back lookups, alternating hit (0xAB -> 3) and miss (0xCD)
    key_mask_in = '1;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        burst_hit = ((i - 2) % 2 == 0);
        chk($sformatf("burst_valid_%0d", i - 2), CW'(phv_valid_out), CW'(1'b1));
        chk($sformatf("burst_hit_%0d", i - 2), CW'(match_hit_out), CW'(burst_hit));
        chk($sformatf("burst_addr_%0d", i - 2), CW'(match_addr_out),
            CW'(burst_hit ? 4'd3 : 4'd0));
        chk($sformatf("burst_phv_%0d", i - 2), phv_out, mk_phv(32'h6000_0000 + 32'(i - 2)));
        if (burst_hit) exp_hits++;
      end
      if (i < 8) begin
        key_in       = '0;
        key_in[7:0]  = (i % 2 == 0) ? 8'hAB : 8'hCD;
        phv_in       = mk_phv(32'h6000_0000 + 32'(i));
        key_valid_in = 1'b1;
      end else begin
        key_valid_in = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("burst_end_valid", CW'(phv_valid_out), CW'(1'b0));
    chk("burst_hit_cnt", CW'(hit_cnt_out), CW'(exp_cnt()));

    // Reset while waiting for a write payload
    send_beat(mk_hdr(8'd2, 4'd1, 8'd7), 1'b0);
    chk("rstw_state_write", CW'(ctrl_state), CW'(2'd1));
    rst = 1'b1;
    #2;
    chk("rstw_state_idle", CW'(ctrl_state), CW'(2'd0));
    chk("rstw_hit_cnt", CW'(hit_cnt_out), CW'(32'd0));
    @(negedge clk);
    rst = 1'b0;
    exp_hits = 0;
    // First beat after reset is a header: id 0, so it is forwarded
    send_beat(DW'(8'h55), 1'b1);
    chk("rstw_first_fwd", CW'(m_tvalid), CW'(1'b1));
    chk("rstw_first_data", CW'(m_tdata), CW'(DW'(8'h55)));
    lookup("rstw_cleared", 8'hAB, 32'h7777_0007, 1'b0, 4'd0);

    // Lookup in the write cycle sees old contents; the next one sees the write
    write_entry(4'd2, 8'd7, '1);
    send_beat(mk_hdr(8'd2, 4'd1, 8'd7), 1'b0);
    key_in       = '0;
    key_in[7:0]  = 8'h55;
    key_mask_in  = '1;
    phv_in       = mk_phv(32'h8888_0008);
    key_valid_in = 1'b1;
    s_tdata      = DW'(8'h55);
    s_tlast      = 1'b1;
    s_tvalid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    phv_in       = mk_phv(32'h8888_0009);
    @(posedge clk);
    @(negedge clk);
    key_valid_in = 1'b0;
    chk("same_cycle_hit", CW'(match_hit_out), CW'(1'b0));
    chk("same_cycle_addr", CW'(match_addr_out), CW'(4'd0));
    chk("same_cycle_phv", phv_out, mk_phv(32'h8888_0008));
    @(posedge clk);
    @(negedge clk);
    chk("next_cycle_hit", CW'(match_hit_out), CW'(1'b1));
    chk("next_cycle_addr", CW'(match_addr_out), CW'(4'd7));
    chk("next_cycle_phv", phv_out, mk_phv(32'h8888_0009));
    exp_hits++;
    @(posedge clk);
    @(negedge clk);
    chk("final_hit_cnt", CW'(hit_cnt_out), CW'(exp_cnt()));
    chk("final_held_addr", CW'(match_addr_out), CW'(4'd7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lookup_engine_tcam.md
LOOKUP_ENGINE_TCAM -- requirements
Module: lookup_engine_tcam

Interface
REQ-001 SHALL take parameter C_S_AXIS_DATA_WIDTH, default 256: control AXIS data width.
REQ-002 SHALL take parameter C_S_AXIS_TUSER_WIDTH, default 128: control AXIS tuser width.
REQ-003 SHALL take parameter PHV_LEN, default 1124: PHV width.
REQ-004 SHALL take parameter KEY_LEN, default 197: key and mask width.
REQ-005 SHALL take parameter DEPTH, default 16: number of table entries, a power of two.
REQ-006 SHALL take parameter LKE_ID, default 2: control-path module id.
REQ-007 SHALL have port clk, input, 1: single clock; every flop on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have ports phv_in (input, PHV_LEN), key_in (input, KEY_LEN), key_mask_in (input, KEY_LEN) and key_valid_in (input, 1): key, mask and PHV from key extraction.
REQ-010 SHALL have ports phv_out (output, PHV_LEN), phv_valid_out (output, 1), match_addr_out (output, log2(DEPTH)), match_hit_out (output, 1) and hit_cnt_out (output, 32).
REQ-011 SHALL have ports c_s_axis_tdata/tuser/tkeep/tvalid/tlast (inputs) and c_m_axis_tdata/tuser/tkeep/tvalid/tlast (outputs): control AXIS, no tready.

Function
REQ-012 SHALL keep per entry a KEY_LEN key, a KEY_LEN mask and a valid bit.
REQ-013 SHALL define entry i as matching when valid[i]=1 and ((key_in ^ key[i]) & mask[i] & key_mask_in) is all zero.
REQ-014 SHALL use two pipeline stages: stage 1 registers the match vector and PHV, stage 2 registers the priority-encoded result; a key_valid_in in cycle N yields phv_valid_out in cycle N+2.
REQ-015 SHALL accept key_valid_in every cycle, with no bubbles and no stall.
REQ-016 SHALL drive match_addr_out with the lowest matching index and match_hit_out=1 when any entry matches; on a miss, match_hit_out=0 and match_addr_out=0.
REQ-017 SHALL hold phv_out, match_addr_out and match_hit_out at their last values when phv_valid_out=0.
REQ-018 SHALL run the control FSM with states C_IDLE, C_WRITE, C_BYPASS and C_DISCARD.
REQ-019 SHALL handle a header beat in C_IDLE as follows: when tvalid=1, tdata[112+:8]==LKE_ID, tdata[124+:4] is 1 (key) or 2 (mask) and tdata[128+:8]<DEPTH, latch the type and index, do not forward the beat, and go to C_WRITE.
REQ-020 SHALL forward any other C_IDLE beat with tvalid=1 to c_m_axis one cycle later, and go to C_BYPASS if tlast=0.
REQ-021 SHALL, in C_WRITE, write the next valid beat's tdata[KEY_LEN-1:0] to the key or mask of the latched index, set valid[index]=1 on a key write only, then go to C_IDLE if tlast=1, otherwise to C_DISCARD.
REQ-022 SHALL drop beats in C_DISCARD up to and including tlast, then return to C_IDLE.
REQ-023 SHALL forward all beats in C_BYPASS with one-cycle latency and return to C_IDLE after tlast.
REQ-024 SHALL return a header with tlast=1 and tdata[112+:8]==LKE_ID to C_IDLE without writing.
REQ-025 SHALL treat a header with valid id but an out-of-range index or type as non-matching and forward it.
REQ-026 SHALL give a lookup in the same cycle as a table write the pre-write contents; the write is visible to lookups from the next cycle.
REQ-027 SHALL drive c_m_axis_tvalid=0 on cycles with nothing to forward.

Reset
REQ-028 SHALL, while rst=1, clear all valid bits, entry keys and masks, phv_out, phv_valid_out, match_addr_out, match_hit_out, hit_cnt_out and c_m_axis_* to 0, and force the FSM to C_IDLE.
REQ-029 SHALL discard a packet interrupted by reset; the first beat after reset is treated as a header.

Configuration
REQ-030 SHALL, with LKE_HIT_CNT_EN defined, increment hit_cnt_out by 1 in each cycle where phv_valid_out=1 and match_hit_out=1, saturating at 0xFFFFFFFF.
REQ-031 SHALL, without LKE_HIT_CNT_EN, tie hit_cnt_out to 0 and synthesize no counter logic.

Verification
REQ-032 SHALL cover: write key 0xAB at index 3 and mask all-ones, then lookup key 0xAB with key_mask all-ones -> match_hit_out=1 and match_addr_out=3 two cycles later.
REQ-033 SHALL cover: entries 2 and 5 both matching key 0x10 -> match_addr_out=2.
REQ-034 SHALL cover: lookup after reset with no writes -> match_hit_out=0 and match_addr_out=0; with LKE_HIT_CNT_EN, hit_cnt_out stays 0.
REQ-035 SHALL cover: a 3-beat packet with id 1 -> forwarded unchanged on c_m_axis with 1-cycle delay and the table unchanged.
REQ-036 SHALL cover: 8 back-to-back key_valid_in cycles alternating hit and miss -> 8 consecutive phv_valid_out cycles with the alternating result, and hit_cnt_out=4 with the macro enabled.
REQ-037 SHALL cover: rst asserted in C_WRITE before the data beat -> no entry written, and the next header is decoded correctly.
